// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: control sequencer for the shared iterative multiply/divide
// datapath. Walks IDLE -> LOAD -> RUN (ITER cycles) -> [FIXUP] -> DONE and
// stalls the pipeline while an operation is in flight.
// Optional feature macro: MULDIV_SIGNED_EN (signed ops insert a FIXUP cycle).
module muldiv_sequencer #(
    parameter int ITER = 32,
    parameter int CW   = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  logic [1:0]    req_op,
    output logic          req_ready,
    input  logic          flush,
    input  logic          hilo_read,
    output logic          stall,
    output logic [CW-1:0] ctrl,
    output logic          hilo_we,
    output logic          busy,
    output logic          done
);

    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    localparam logic [CW-1:0] CTRL_IDLE  = CW'(6'd0);
    localparam logic [CW-1:0] CTRL_LOAD  = CW'(6'd1);
    localparam logic [CW-1:0] CTRL_MUL   = CW'(6'd26);
    localparam logic [CW-1:0] CTRL_DIV   = CW'(6'd27);
    localparam logic [CW-1:0] CTRL_FIXUP = CW'(6'd40);
    localparam logic [CW-1:0] CTRL_DONE  = CW'(6'b111111);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        FIXUP,
        DONE
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             op_div;     // latched req_op[0]
    logic             op_signed;  // latched req_op[1] when signed ops are enabled
    logic             accept;

    assign accept = req_valid && req_ready && !flush;

`ifdef MULDIV_SIGNED_EN
    // Signed ops take the FIXUP detour before write-back.
    always_ff @(posedge clk) begin
        if (rst)         op_signed <= 1'b0;
        else if (accept) op_signed <= req_op[1];
    end
`else
    // Signedness is ignored: every op runs as unsigned.
    logic unused_op_sign;
    assign unused_op_sign = req_op[1];
    assign op_signed      = 1'b0;
`endif

    // State register, latched op kind and iteration counter.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            op_div <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) op_div <= req_op[0];
            if (state == LOAD)
                cnt <= '0;
            else if (state == RUN && cnt != CNT_LAST)
                cnt <= cnt + 1'b1;
        end
    end

    // Next-state logic; flush aborts everything except the committing DONE cycle.
    // NOTE: defaults are assigned first so no path through the case infers a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (accept) state_nxt = LOAD;
            LOAD:  state_nxt = flush ? IDLE : RUN;
            RUN: begin
                if (flush)
                    state_nxt = IDLE;
                else if (cnt == CNT_LAST)
                    state_nxt = op_signed ? FIXUP : DONE;
            end
            FIXUP: state_nxt = flush ? IDLE : DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from registered state only (no input-to-ctrl path).
    always_comb begin
        ctrl      = CTRL_IDLE;
        hilo_we   = 1'b0;
        done      = 1'b0;
        busy      = 1'b1;
        req_ready = 1'b0;
        unique case (state)
            IDLE: begin
                busy      = 1'b0;
                req_ready = 1'b1;
            end
            LOAD:  ctrl = CTRL_LOAD;
            RUN:   ctrl = op_div ? CTRL_DIV : CTRL_MUL;
            FIXUP: ctrl = CTRL_FIXUP;
            DONE: begin
                ctrl    = CTRL_DONE;
                hilo_we = 1'b1;
                done    = 1'b1;
            end
            default: begin
                busy      = 1'b0;
                req_ready = 1'b1;
            end
        endcase
    end

    // Hold the pipeline while a mult/div is in flight and it wants the unit or HI/LO.
    assign stall = busy && (req_valid || hilo_read);

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Sequencer for the shared iterative multiply/divide datapath in the EX stage. Accepts one MULT/DIV request at a time from the pipeline and drives the datapath's 6-bit control word through load, iteration, optional sign fix-up and HI/LO write-back. Stalls the pipeline for new mult/div requests or HI/LO reads while an operation is in flight, and aborts cleanly on a pipeline flush.

## Interface
Parameters:
- ITER, 32: iteration cycles per operation; counter width is $clog2(ITER).
- CW, 6: control word width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; one clock, synchronous, active-high.
- req_valid  in  1  EX stage holds a MULT/MULTU/DIV/DIVU.
- req_op  in  2  00 MULTU, 01 DIVU, 10 MULT, 11 DIV.
- req_ready  out  1  high only in IDLE; a request is accepted on `req_valid && req_ready && !flush`.
- flush  in  1  pipeline flush; aborts the in-flight operation.
- hilo_read  in  1  MFHI/MFLO in ID stage.
- stall  out  1  pipeline stall request.
- ctrl  out  CW  control word to the datapath.
- hilo_we  out  1  HI/LO write enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, LOAD, RUN, FIXUP, DONE. State, latched op and counter are registered.
- Outputs are decoded from registered state only; there is no input-to-ctrl combinational path.
- ctrl encoding:
  - IDLE: 6'd0.
  - LOAD: 6'd1.
  - RUN: 6'd26 for multiply, 6'd27 for divide.
  - FIXUP: 6'd40.
  - DONE: 6'b111111.
- IDLE:
  - On accept, latch req_op and go to LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - Clear the counter.
  - Go to RUN.
- RUN:
  - Increment the counter each cycle.
  - When counter == ITER-1: go to FIXUP if the latched op is signed and MULDIV_SIGNED_EN is defined; otherwise go to DONE.
- FIXUP: go to DONE.
- DONE:
  - Assert hilo_we=1 and done=1.
  - Go to IDLE.
- stall = busy && (req_valid || hilo_read). There is no stall in IDLE, so a request is accepted without stalling.
- flush:
  - In LOAD, RUN or FIXUP: next state is IDLE, no hilo_we, no done.
  - In DONE: ignored; the write-back commits.
  - In IDLE: blocks acceptance.
- rst has priority over flush and all other inputs.

## Timing
- Reset values: state IDLE, counter 0, ctrl 0, hilo_we 0, done 0, busy 0, req_ready 1, stall 0.
- Accept in cycle T:
  - LOAD in T+1.
  - RUN in T+2 .. T+1+ITER.
  - Unsigned: DONE in T+2+ITER (T+34 at the default).
  - Signed with the macro: FIXUP in T+2+ITER, DONE in T+3+ITER (T+35).
- req_ready returns high in the cycle after DONE. Back-to-back ops are therefore separated by at least one IDLE cycle.
- hilo_read in the DONE cycle stalls. The read proceeds in the following cycle and sees the new HI/LO.
- A flush asserted in cycle F makes ctrl 0 in cycle F+1.
- A reset asserted mid-operation gives IDLE outputs on the next edge, with no write-back.
- The counter never wraps. It is cleared in LOAD and stops at ITER-1.

## Configuration
- MULDIV_SIGNED_EN
  - Defined: req_op[1] selects signed. Signed ops insert one FIXUP cycle (ctrl=6'd40) before DONE.
  - Undefined: req_op[1] is ignored, all ops are treated as unsigned, and the FIXUP state is never entered.

## Test plan
- Reset, then idle: ctrl=0, busy=0, req_ready=1, stall=0.
- MULTU accepted at T:
  - ctrl=1 at T+1.
  - ctrl=26 for 32 cycles.
  - ctrl=63 with hilo_we=1 and done=1 at T+34.
  - req_ready=1 at T+35.
- DIV (signed) with macro: ctrl=27 ×32, then 40 at T+34, then 63 at T+35. Without macro: identical to DIVU, with DONE at T+34.
- hilo_read held from T+5 through DONE: stall=1 through T+34, stall=0 at T+35. A second DIVU arriving mid-run stalls, then is accepted at T+35.
- flush at RUN cycle 10: IDLE next cycle, ctrl=0, hilo_we never asserted. flush in the DONE cycle: hilo_we=1 still asserted.
- rst pulsed at RUN cycle 20: all outputs at reset values next cycle. A new request is accepted in the following cycle.
